// File: rtl/ipu_coord_tx.sv
`default_nettype none
// ============================================================================
// Module      : ipu_coord_tx
// Description : Queues selected tile coordinates in a 4-entry FIFO and
//               delivers them one at a time over an interrupt/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module ipu_coord_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       coord_valid,
  input  logic [3:0] coord_in,
  input  logic       int_ack,
  output logic       ipu_int,
  output logic [3:0] grid_coord,
  output logic       fifo_full,
  output logic [3:0] drop_cnt
);

  localparam int         DEPTH     = 4;
  localparam logic [3:0] MAX_COORD = 4'd8;
  localparam logic [2:0] FULL_CNT  = 3'd4;
  localparam logic [3:0] DROP_MAX  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACKWAIT = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_mem [0:DEPTH-1];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic [3:0] r_grid;
  logic [3:0] r_drop;

  logic w_pop;
  logic w_push;
  logic w_full;
  logic w_legal;
  logic w_drop;

  // A pop only happens as the acknowledge of a live request, and a request
  // is only live while the queue is non-empty; the count term is a safeguard.
  assign w_full  = (r_count == FULL_CNT);
  assign w_legal = (coord_in <= MAX_COORD);
  assign w_pop   = (r_state == ST_REQ) && int_ack && (r_count != 3'd0);
  assign w_push  = coord_valid && w_legal && (!w_full || w_pop);
  assign w_drop  = coord_valid && !w_push;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_grid  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_count != 3'd0) begin
            r_state <= ST_REQ;
            r_grid  <= r_mem[r_rd_ptr];
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            r_state <= ST_ACKWAIT;
          end
        end
        ST_ACKWAIT: begin
          if (!int_ack) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When full with a same-edge pop, the write lands on the slot being
  // popped; its value was already captured into grid_coord on entry to REQ.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_mem[i] <= 4'd0;
        end else if (w_push && (r_wr_ptr == 2'(i))) begin
          r_mem[i] <= coord_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop <= 4'd0;
    end else if (w_drop && (r_drop != DROP_MAX)) begin
      r_drop <= r_drop + 4'd1;
    end
  end

  assign ipu_int    = (r_state == ST_REQ);
  assign grid_coord = r_grid;
  assign fifo_full  = w_full;
  assign drop_cnt   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_ipu_coord_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipu_coord_tx
// Description : Directed and random stimulus against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ipu_coord_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coord_valid = 1'b0;
  logic [3:0] coord_in = 4'd0;
  logic       int_ack = 1'b0;
  logic       ipu_int;
  logic [3:0] grid_coord;
  logic       fifo_full;
  logic [3:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  // Model: pending coordinates, handshake phase (0 idle, 1 requesting,
  // 2 waiting for ack release), last delivered coordinate, drop tally.
  int mq[$];
  int m_phase = 0;
  int m_gc    = 0;
  int m_drop  = 0;

  ipu_coord_tx dut (
    .clk        (clk),
    .rst        (rst),
    .coord_valid(coord_valid),
    .coord_in   (coord_in),
    .int_ack    (int_ack),
    .ipu_int    (ipu_int),
    .grid_coord (grid_coord),
    .fifo_full  (fifo_full),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ipu_int",    {31'd0, ipu_int},    (m_phase == 1) ? 32'd1 : 32'd0);
    chk("grid_coord", {28'd0, grid_coord}, m_gc);
    chk("fifo_full",  {31'd0, fifo_full},  (mq.size() == 4) ? 32'd1 : 32'd0);
    chk("drop_cnt",   {28'd0, drop_cnt},   m_drop);
  endtask

  task automatic model_edge(input bit v, input int c, input bit a);
    bit pop;
    bit push;
    pop  = (m_phase == 1) && a;
    push = v && (c <= 8) && ((mq.size() < 4) || pop);
    if (v && !push && m_drop < 15) m_drop++;
    case (m_phase)
      0: if (mq.size() > 0) begin m_phase = 1; m_gc = mq[0]; end
      1: if (a) m_phase = 2;
      default: if (!a) m_phase = 0;
    endcase
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(c);
  endtask

  task automatic step(input bit v, input int c, input bit a);
    @(negedge clk);
    coord_valid = v;
    coord_in    = c[3:0];
    int_ack     = a;
    @(posedge clk);
    model_edge(v, c, a);
    #1;
    check_all();
  endtask

  // Wait (bounded) for a request, check its coordinate, ack one cycle.
  task automatic serve(input int exp);
    for (int i = 0; i < 8 && !ipu_int; i++) step(0, 0, 0);
    chk("req_raised", {31'd0, ipu_int}, 32'd1);
    chk("req_coord", {28'd0, grid_coord}, exp);
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst         = 1'b0;
    coord_valid = 1'b0;
    int_ack     = 1'b0;
    #1;
    mq.delete();
    m_phase = 0;
    m_gc    = 0;
    m_drop  = 0;
    chk("rst_async_int", {31'd0, ipu_int}, 32'd0);
    chk("rst_async_gc", {28'd0, grid_coord}, 32'd0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit rv;
    bit ra;
    int rc;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_drop", {28'd0, drop_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single event with one-cycle latency
    step(1, 6, 0);
    chk("single_lat0", {31'd0, ipu_int}, 32'd0);
    step(0, 0, 0);
    chk("single_int", {31'd0, ipu_int}, 32'd1);
    chk("single_gc", {28'd0, grid_coord}, 32'd6);
    step(0, 0, 1);
    chk("single_drop_int", {31'd0, ipu_int}, 32'd0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("single_no_rereq", {31'd0, ipu_int}, 32'd0);

    // Ordering
    step(1, 2, 0);
    step(1, 5, 0);
    step(1, 8, 0);
    serve(2);
    chk("order_idle_gap", {31'd0, ipu_int}, 32'd0);
    serve(5);
    serve(8);

    // Overflow
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, i, 0);
      if (i == 3) chk("ovf_full4", {31'd0, fifo_full}, 32'd1);
    end
    chk("ovf_drop", {28'd0, drop_cnt}, 32'd1);
    chk("ovf_full", {31'd0, fifo_full}, 32'd1);
    for (int i = 0; i < 4; i++) serve(i);
    chk("ovf_empty", {31'd0, fifo_full}, 32'd0);

    // Illegal values and saturation
    do_reset();
    step(1, 9, 0);
    step(1, 15, 0);
    step(0, 0, 0);
    chk("illegal_int", {31'd0, ipu_int}, 32'd0);
    chk("illegal_drop", {28'd0, drop_cnt}, 32'd2);
    for (int i = 0; i < 17; i++) step(1, 9 + (i % 7), 0);
    chk("drop_sat", {28'd0, drop_cnt}, 32'd15);

    // Push while full with same-edge pop
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, i, 0);
    chk("pf_full", {31'd0, fifo_full}, 32'd1);
    step(1, 7, 1);
    chk("pf_still_full", {31'd0, fifo_full}, 32'd1);
    chk("pf_drop", {28'd0, drop_cnt}, 32'd0);
    step(0, 0, 0);
    serve(2);
    serve(3);
    serve(4);
    serve(7);

    // Reset in REQ with entries queued
    do_reset();
    step(1, 3, 0);
    step(1, 4, 0);
    step(1, 5, 0);
    chk("rr_in_req", {31'd0, ipu_int}, 32'd1);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("rr_no_req", {31'd0, ipu_int}, 32'd0);

    // Random traffic against the model
    ra = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 2) == 0);
      rc = ($urandom_range(0, 5) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      if ($urandom_range(0, 2) == 0) ra = ~ra;
      step(rv, rc, ra);
      if (i == 200) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
